// File: rtl/queue_pkg.sv
// queue_pkg -- shared constants and types for the queue/stack family.
//
// Contents:
//   QUEUE_WIDTH_DEF : default data word width in bits (18)
//   QUEUE_SIZE_DEF  : default log2 of storage depth (4 -> 16 entries)
//   queue_op_e      : decoded accepted operation for one cycle
//   depth_of()      : entry count for a given log2 size
package queue_pkg;

  localparam int unsigned QUEUE_WIDTH_DEF = 18;
  localparam int unsigned QUEUE_SIZE_DEF  = 4;

  // Bit 1 = accepted push, bit 0 = accepted pop.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } queue_op_e;

  function automatic int unsigned depth_of(input int unsigned size);
    return 32'd1 << size;
  endfunction

endpackage : queue_pkg

// File: rtl/queue.sv
// queue -- synchronous single-clock FIFO with registered read data.
//
// Parameters:
//   QUEUE_WIDTH : data word width in bits
//   QUEUE_SIZE  : log2 of depth (depth = 2**QUEUE_SIZE entries)
//
// Ports:
//   clk        in   rising-edge clock for all state
//   reset      in   synchronous active-high reset, dominant over push/pop
//   push       in   write request; data_in sampled on the same edge
//   pop        in   read request from the oldest entry
//   data_in    in   write data
//   data_out   out  registered read data, held between accepted pops
//   data_valid out  one-cycle pulse after an accepted pop
//   full       out  count == 2**QUEUE_SIZE
//   empty      out  count == 0
//   count      out  current occupancy (QUEUE_SIZE+1 bits)
//
// Optional build macro QUEUE_ERR_EN adds:
//   overflow   out  sticky: push ignored because full with no pop
//   underflow  out  sticky: pop ignored because empty
//   Both clear only on reset.
module queue
  import queue_pkg::*;
#(
  parameter int unsigned QUEUE_WIDTH = QUEUE_WIDTH_DEF,
  parameter int unsigned QUEUE_SIZE  = QUEUE_SIZE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [QUEUE_WIDTH-1:0] data_in,
  output logic [QUEUE_WIDTH-1:0] data_out,
  output logic                   data_valid,
  output logic                   full,
  output logic                   empty,
  output logic [QUEUE_SIZE:0]    count
`ifdef QUEUE_ERR_EN
  ,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int unsigned DEPTH = depth_of(QUEUE_SIZE);
  localparam int unsigned PW    = QUEUE_SIZE;
  localparam int unsigned CW    = QUEUE_SIZE + 1;

  logic [QUEUE_WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  logic      accept_push;
  logic      accept_pop;
  queue_op_e op;

  // Status flags come straight from the registered count.
  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
  end

  // A pop frees a slot in the same cycle, so a push against a full
  // queue is still taken when it is paired with a pop.
  always_comb begin
    accept_pop  = pop && !empty;
    accept_push = push && (!full || accept_pop);
    op          = queue_op_e'({accept_push, accept_pop});
  end

  // Storage has no reset; entries are discarded logically via the pointers.
  always_ff @(posedge clk) begin
    if (!reset && accept_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= accept_pop;
      if (accept_pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      if (accept_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      case (op)
        OP_PUSH: count <= count + CW'(1);
        OP_POP:  count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef QUEUE_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !accept_push) begin
        overflow <= 1'b1;
      end
      if (pop && !accept_pop) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule : queue
